// File: rtl/bin2qdi_tx_enable_1of4.sv
// Clocked binary-to-QDI e1of4 transmitter: input FIFO, Re synchronizer and four-phase handshake FSM.
// Optional Re protocol checker enabled by BIN2QDI_TX_PROTOCOL_CHECK_EN.
module bin2qdi_tx_enable_1of4 #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [3:0]       R,
    input  logic             Re,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count,
    output logic             err,
    inout  wire              VDD,
    inout  wire              GND
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_EN  = 2'd2
    } state_t;

    // Supply pins carry no logic.
    logic unused_supply;
    assign unused_supply = VDD ^ GND;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   re_s;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             din_ready_q;
    logic             push_c;
    logic             pop_c;
    logic [1:0]       head_c;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       r_q;
    logic [3:0]       r_d;
    logic             cnt_inc_c;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             err_q;

    // Re is asynchronous; only the last synchronizer stage feeds logic.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Re};
        end
    end
    assign re_s = sync_q[SYNC_STAGES-1];

    assign push_c = din_valid && din_ready_q;
    assign head_c = mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (push_c && !pop_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            din_ready_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q       <= occ_d;
            din_ready_q <= (occ_d != OCC_W'(DEPTH));
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        pop_c     = 1'b0;
        cnt_inc_c = 1'b0;
        case (state_q)
            IDLE: begin
                r_d = 4'b0000;
                if ((occ_q != '0) && re_s) begin
                    pop_c   = 1'b1;
                    r_d     = 4'b0001 << head_c;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!re_s) begin
                    r_d       = 4'b0000;
                    cnt_inc_c = 1'b1;
                    state_d   = WAIT_EN;
                end
            end
            WAIT_EN: begin
                r_d = 4'b0000;
                if (re_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                r_d     = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            r_q     <= 4'b0000;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            if (cnt_inc_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            busy_q <= (state_d != IDLE) || (occ_d != '0);
        end
    end

`ifdef BIN2QDI_TX_PROTOCOL_CHECK_EN
    logic re_s_prev_q;
    logic err_set_c;

    // An Re fall with neutral rails, or an Re rise while data is presented, breaks the handshake.
    assign err_set_c = (re_s_prev_q && !re_s && ((state_q == IDLE) || (state_q == WAIT_EN)))
                    || (!re_s_prev_q && re_s && (state_q == WAIT_ACK));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            re_s_prev_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            re_s_prev_q <= re_s;
            err_q       <= err_q | err_set_c;
        end
    end

    always @(posedge CLK) begin
        if (!RESET && err_set_c && !err_q) begin
            $display("BIN2QDI_TX_1of4: protocol error, Re=%b state=%d @time %t",
                     re_s, state_q, $time);
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign din_ready  = din_ready_q;
    assign R          = r_q;
    assign busy       = busy_q;
    assign sent_count = cnt_q;
    assign err        = err_q;

endmodule
